// File: rtl/register_file_if.sv
// Register-file access bus: write port plus two read ports, bundled for the
// master (requester) and slave (register file) sides.
interface register_file_if #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_WIDTH  = 4
);

   logic                  _regWrite;
   logic [REG_WIDTH-1:0]  _regSrcA;
   logic [REG_WIDTH-1:0]  _regSrcB;
   logic [REG_WIDTH-1:0]  _regDest;
   logic [DATA_WIDTH-1:0] _writeVal;
   logic [DATA_WIDTH-1:0] valueA;
   logic [DATA_WIDTH-1:0] valueB;

   modport master (
      output _regWrite,
      output _regSrcA,
      output _regSrcB,
      output _regDest,
      output _writeVal,
      input  valueA,
      input  valueB
   );

   modport slave (
      input  _regWrite,
      input  _regSrcA,
      input  _regSrcB,
      input  _regDest,
      input  _writeVal,
      output valueA,
      output valueB
   );

endinterface

// File: rtl/register_file.sv
// 2**REG_WIDTH x DATA_WIDTH register file, one write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_WIDTH  = 4
) (
   input  logic             _CLK,
   input  logic             _RST_N,
   register_file_if.slave   bus
);

   localparam int NumRegs = 2 ** REG_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [NumRegs];
   logic [DATA_WIDTH-1:0] w_storedA;
   logic [DATA_WIDTH-1:0] w_storedB;

   // Reset outranks a concurrent write, so a write in the reset cycle is dropped.
   always_ff @(posedge _CLK) begin
      if (!_RST_N) begin
         for (int i = 0; i < NumRegs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (bus._regWrite) begin
         r_regs[bus._regDest] <= bus._writeVal;
      end
   end

   assign w_storedA = r_regs[bus._regSrcA];
   assign w_storedB = r_regs[bus._regSrcB];

`ifdef REGFILE_BYPASS_EN
   logic w_writeLive;
   logic w_bypassA;
   logic w_bypassB;

   // A write that will actually land this edge is visible on the read ports now.
   assign w_writeLive = bus._regWrite & _RST_N;
   assign w_bypassA   = w_writeLive & (bus._regSrcA == bus._regDest);
   assign w_bypassB   = w_writeLive & (bus._regSrcB == bus._regDest);

   assign bus.valueA = w_bypassA ? bus._writeVal : w_storedA;
   assign bus.valueB = w_bypassB ? bus._writeVal : w_storedB;
`else
   assign bus.valueA = w_storedA;
   assign bus.valueB = w_storedB;
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array model.
// Honours REGFILE_BYPASS_EN when the same macro is defined for the bench.
module tb_register_file;

   localparam int DataWidth = 8;
   localparam int RegWidth  = 4;
   localparam int NumRegs   = 2 ** RegWidth;

   logic clk;
   logic rstN;

   int checkCount;
   int errorCount;

   logic [DataWidth-1:0] model [NumRegs];

   register_file_if #(.DATA_WIDTH(DataWidth), .REG_WIDTH(RegWidth)) bus ();

   register_file #(.DATA_WIDTH(DataWidth), .REG_WIDTH(RegWidth)) dut (
      ._CLK   (clk),
      ._RST_N (rstN),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DataWidth-1:0] observed,
                              input logic [DataWidth-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic we,
                                input logic [RegWidth-1:0] srcA, input logic [RegWidth-1:0] srcB,
                                input logic [RegWidth-1:0] dest, input logic [DataWidth-1:0] val);
      rstN          = rst;
      bus._regWrite = we;
      bus._regSrcA  = srcA;
      bus._regSrcB  = srcB;
      bus._regDest  = dest;
      bus._writeVal = val;
      #1;
   endtask

   // What a read port should show right now, from the model and the live inputs.
   function automatic logic [DataWidth-1:0] expectedRead(input logic [RegWidth-1:0] idx);
`ifdef REGFILE_BYPASS_EN
      if (bus._regWrite && rstN && idx == bus._regDest) return bus._writeVal;
`endif
      return model[idx];
   endfunction

   // Advance one rising edge and update the model from the inputs held across it.
   task automatic clockEdge();
      @(posedge clk);
      if (!rstN) begin
         for (int i = 0; i < NumRegs; i++) model[i] = '0;
      end else if (bus._regWrite) begin
         model[bus._regDest] = bus._writeVal;
      end
      #1;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      for (int i = 0; i < NumRegs; i++) model[i] = '0;
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd15, 4'd0, 8'd0);
      clockEdge();

      // Reset state on the extreme indices
      applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 8'd0);
      checkOutput("reset_valueA_idx0", bus.valueA, 8'd0);
      checkOutput("reset_valueB_idx15", bus.valueB, 8'd0);

      // Register 0 is writable; two writes then read both back
      applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 8'd10);
      clockEdge();
      applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd2, 8'd7);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 8'd0);
      checkOutput("write_reg2_valueA", bus.valueA, 8'd7);
      checkOutput("write_reg0_valueB", bus.valueB, 8'd10);

      // Disabled write must not land
      applyStimulus(1'b1, 1'b0, 4'd2, 4'd5, 4'd2, 8'd11);
      checkOutput("nowrite_valueA", bus.valueA, 8'd7);
      checkOutput("unwritten_reg5", bus.valueB, 8'd0);
      clockEdge();
      checkOutput("nowrite_after_edge", bus.valueA, 8'd7);

      // Single-edge write visible immediately, then held
      applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 4'd2, 8'd55);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 4'd2, 4'd5, 4'd2, 8'd14);
      checkOutput("write55_visible", bus.valueA, 8'd55);
      clockEdge();
      checkOutput("write55_held", bus.valueA, 8'd55);

      // Same-register read during write: bypass or old value
      applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd3, 8'd20);
      clockEdge();
      applyStimulus(1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 8'd42);
`ifdef REGFILE_BYPASS_EN
      checkOutput("rw_same_before_edge_A", bus.valueA, 8'd42);
      checkOutput("rw_same_before_edge_B", bus.valueB, 8'd42);
`else
      checkOutput("rw_same_before_edge_A", bus.valueA, 8'd20);
      checkOutput("rw_same_before_edge_B", bus.valueB, 8'd20);
`endif
      clockEdge();
      applyStimulus(1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 8'd0);
      checkOutput("rw_same_after_edge", bus.valueA, 8'd42);

      // Top index is a real register
      applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd15, 8'hA5);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 4'd15, 4'd15, 4'd0, 8'd0);
      checkOutput("top_index_A", bus.valueA, 8'hA5);
      checkOutput("top_index_B", bus.valueB, 8'hA5);

      // Reset beats a simultaneous write and clears everything
      applyStimulus(1'b0, 1'b1, 4'd2, 4'd0, 4'd2, 8'd99);
      clockEdge();
      for (int i = 0; i < NumRegs; i++) begin
         applyStimulus(1'b1, 1'b0, RegWidth'(i), RegWidth'(NumRegs - 1 - i), 4'd0, 8'd0);
         checkOutput("post_reset_A", bus.valueA, 8'd0);
         checkOutput("post_reset_B", bus.valueB, 8'd0);
      end

      // Randomized traffic against the array model, with occasional resets
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) != 0),
                       RegWidth'($urandom), RegWidth'($urandom),
                       RegWidth'($urandom), DataWidth'($urandom));
         checkOutput("rand_valueA", bus.valueA, expectedRead(bus._regSrcA));
         checkOutput("rand_valueB", bus.valueB, expectedRead(bus._regSrcB));
         clockEdge();
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of every register and data port.
REQ-002 The block SHALL have parameter REG_WIDTH, default 4, meaning the register-index width; the file holds 2**REG_WIDTH registers.
REQ-003 The block SHALL have port _CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port _RST_N, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port _regWrite, input, 1 bit, the write enable.
REQ-006 The block SHALL have port _regSrcA, input, REG_WIDTH bits, the read-port A index.
REQ-007 The block SHALL have port _regSrcB, input, REG_WIDTH bits, the read-port B index.
REQ-008 The block SHALL have port _regDest, input, REG_WIDTH bits, the write index.
REQ-009 The block SHALL have port _writeVal, input, DATA_WIDTH bits, the write data.
REQ-010 The block SHALL have port valueA, output, DATA_WIDTH bits, the contents of register _regSrcA.
REQ-011 The block SHALL have port valueB, output, DATA_WIDTH bits, the contents of register _regSrcB.

Function
REQ-012 The block SHALL write _writeVal into register _regDest on the _CLK rising edge when _regWrite=1 and _RST_N=1.
REQ-013 The block SHALL leave all registers unchanged on any edge where _regWrite=0, regardless of _regDest or _writeVal.
REQ-014 The block SHALL drive valueA and valueB combinationally from the addressed registers, with zero-cycle read latency.
REQ-015 The block SHALL make a written value visible on the read ports immediately after the writing edge.
REQ-016 The block SHALL treat every register, including index 0, as fully writable, with no hard-wired zero.
REQ-017 The block SHALL allow both read ports to address the same register, and SHALL return the same value on both.
REQ-018 The block SHALL treat all indices as in range (2**REG_WIDTH entries) and SHALL apply no wrap-around or masking.
REQ-019 The block SHALL support reading and writing the same register in the same cycle; without bypass, the read returns the old value until the edge.

Reset
REQ-020 The block SHALL clear every register to 0 on a _CLK rising edge with _RST_N=0, so valueA=valueB=0 for any index afterwards.
REQ-021 The block SHALL give reset priority over write, so an edge with _RST_N=0 and _regWrite=1 stores nothing.
REQ-022 The block SHALL abort a write asserted mid-operation when reset is asserted, leaving all registers 0 after that edge.

Configuration
REQ-023 With macro REGFILE_BYPASS_EN defined, the block SHALL drive _writeVal on any read port whose index equals _regDest while _regWrite=1 and _RST_N=1.
REQ-024 With macro REGFILE_BYPASS_EN undefined, the block SHALL drive stored contents only on the read ports, per REQ-019.

Verification
REQ-025 Reset, then read indices 0 and 15 -> valueA=0 and valueB=0.
REQ-026 Write 10 to register 0, then write 7 to register 2, then set _regWrite=0, _regSrcA=2, _regSrcB=0 -> valueA=7, valueB=10.
REQ-027 With _regWrite=0, _regDest=2, _writeVal=11 and _regSrcB=5 -> valueA stays 7 and valueB=0 (register 5 never written).
REQ-028 Set _regWrite=1, _regDest=2, _writeVal=55 for one edge -> valueA=55 after that edge; then set _regWrite=0, _writeVal=14 -> valueA stays 55.
REQ-029 Assert _RST_N=0 together with _regWrite=1 and _writeVal=99 -> all reads return 0 after the edge.
REQ-030 With REGFILE_BYPASS_EN defined, set _regSrcA=_regDest=3, _regWrite=1, _writeVal=42 -> valueA=42 before the edge; with the macro undefined -> the old value until the edge.
